// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types and constants for the MIPS datapath.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clr wins over inc. Reusable for perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && (count != '1)) count <= count + W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: drives a combinational imem, buffers one word for decode.
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter int          PROG_LEN = 3,
  parameter int unsigned RESET_PC = 0,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   instr_count
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic            buf_free, pc_in_range, capture, handshake, start_ok;

  assign buf_free    = !out_valid || out_ready;
  assign pc_in_range = pc < PC_W'(PROG_LEN);
  assign capture     = (state == RUN) && !redirect_valid && buf_free && pc_in_range;
  assign handshake   = out_valid && out_ready;
  assign start_ok    = start && (state != RUN);

  assign imem_addr = pc;
  assign imem_en   = capture;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= PC_W'(RESET_PC);
      out_valid <= 1'b0;
      out_instr <= NOP_WORD;
      out_pc    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            pc    <= PC_W'(RESET_PC);
          end
        end
        RUN: begin
          // Redirect flushes the buffer even if decode takes the word this cycle.
          if (redirect_valid) begin
            pc        <= redirect_target;
            out_valid <= 1'b0;
          end else if (buf_free) begin
            if (pc_in_range) begin
              out_instr <= imem_rdata;
              out_pc    <= pc;
              out_valid <= 1'b1;
              pc        <= pc + PC_W'(1);
            end else begin
              // Past the program end: finish only once the last word has drained.
              out_valid <= 1'b0;
              if (!out_valid) state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .inc   (handshake),
    .count (instr_count)
  );

endmodule
